// File: rtl/stack_dump_if.sv
// Byte stream from the stack dump engine to its sink (normally the debug UART).
// valid/ready: a byte moves on a rising edge with tx_valid=1 and tx_ready=1; while stalled the source holds tx_data/tx_valid.
interface stack_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/stack_dump.sv
// Snapshots a hardware stack on start and streams it as a framed byte sequence:
// 0xA5, DEPTH[7:0], then every entry MSB first, zero padded to whole bytes.
module stack_dump #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:DEPTH-1][WIDTH-1:0]   data_raw,
    stack_dump_if.master                  tx,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    dbg_state
);
    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int PW    = BYTES * 8;
    localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [EW-1:0] LAST_ENTRY = EW'(DEPTH - 1);
    localparam logic [BW-1:0] BYTE_TOP   = BW'(BYTES - 1);
    localparam logic [7:0]    LEN_BYTE   = 8'(DEPTH);
    localparam logic [7:0]    HDR_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [0:DEPTH-1][WIDTH-1:0]   snap;
    logic [EW-1:0]                 entry_idx;
    logic [BW-1:0]                 byte_idx;
    logic [PW-1:0]                 cur_word;
    logic [7:0]                    data_byte;
    logic                          last_byte;

    assign last_byte = (entry_idx == LAST_ENTRY) && (byte_idx == '0);
    assign cur_word  = PW'(snap[entry_idx]);
    assign data_byte = 8'(cur_word >> {byte_idx, 3'b000});
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions only ever look at tx_ready from a state where tx_valid is 1.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_HEADER;
            S_HEADER: if (tx.tx_ready) state_nxt = S_LEN;
            S_LEN:    if (tx.tx_ready) state_nxt = S_DATA;
            S_DATA:   if (tx.tx_ready && last_byte) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_HEADER: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HDR_BYTE;
                busy        = 1'b1;
            end
            S_LEN: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = LEN_BYTE;
                busy        = 1'b1;
            end
            S_DATA: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = data_byte;
                busy        = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                tx.tx_valid = 1'b0;
            end
        endcase
    end

    // The whole stack is captured on the start edge so later pushes/pops cannot tear the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap      <= '0;
            entry_idx <= '0;
            byte_idx  <= '0;
        end else if (state == S_IDLE && start) begin
            snap      <= data_raw;
            entry_idx <= '0;
            byte_idx  <= BYTE_TOP;
        end else if (state == S_DATA && tx.tx_ready) begin
            if (byte_idx == '0) begin
                byte_idx  <= BYTE_TOP;
                entry_idx <= entry_idx + EW'(1);
            end else begin
                byte_idx <= byte_idx - BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_stack_dump.sv
// Directed bench for stack_dump: default 16x16 instance plus 12x3 and 8x2 instances.
module tb_stack_dump;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_dump_if if0 ();
    stack_dump_if if1 ();
    stack_dump_if if2 ();

    logic                start0, start1, start2;
    logic [0:15][15:0]   dr0;
    logic [0:2][11:0]    dr1;
    logic [0:1][7:0]     dr2;
    logic                busy0, busy1, busy2;
    logic                done0, done1, done2;
    logic [2:0]          dbg0, dbg1, dbg2;

    stack_dump dut0 (.clk(clk), .rst(rst), .start(start0), .data_raw(dr0), .tx(if0),
                     .busy(busy0), .done(done0), .dbg_state(dbg0));
    stack_dump #(.WIDTH(12), .DEPTH(3)) dut1 (.clk(clk), .rst(rst), .start(start1), .data_raw(dr1),
                     .tx(if1), .busy(busy1), .done(done1), .dbg_state(dbg1));
    stack_dump #(.WIDTH(8), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .start(start2), .data_raw(dr2),
                     .tx(if2), .busy(busy2), .done(done2), .dbg_state(dbg2));

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    logic bp_mode = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] e0, input logic [15:0] e1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h10);
        exp_q.push_back(e0[15:8]);
        exp_q.push_back(e0[7:0]);
        exp_q.push_back(e1[15:8]);
        exp_q.push_back(e1[7:0]);
        for (int i = 0; i < 28; i++) exp_q.push_back(8'h00);
    endtask

    // Called #1 after a rising edge; returns #1 after edge E, i.e. inside cycle E+1.
    task automatic start_dump0();
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic wait_done0(input int n0, output int n);
        n = n0;
        while (!done0 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Scoreboard for the default instance: accepted bytes and stall stability.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", if0.tx_valid, 1);
                check("stall_data", if0.tx_data, prev_data);
            end
            if (if0.tx_valid && if0.tx_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("byte", if0.tx_data, exp_q.pop_front());
            end
            if (if0.tx_valid && !if0.tx_ready) stall_cnt++;
            prev_stall = if0.tx_valid && !if0.tx_ready;
            prev_data  = if0.tx_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) if0.tx_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [7:0] exp1 [8] = '{8'hA5, 8'h03, 8'h0F, 8'hFF, 8'h01, 8'h23, 8'h08, 8'h00};
    logic [7:0] exp2 [4] = '{8'hA5, 8'h02, 8'h5A, 8'hC3};

    initial begin
        int n;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        if0.tx_ready = 1'b0; if1.tx_ready = 1'b1; if2.tx_ready = 1'b1;
        dr0 = '0; dr0[0] = 16'h1234; dr0[1] = 16'hABCD;
        dr1[0] = 12'hFFF; dr1[1] = 12'h123; dr1[2] = 12'h800;
        dr2[0] = 8'h5A; dr2[1] = 8'hC3;

        // asynchronous reset, checked before any clock edge
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_valid", if0.tx_valid, 0);
        check("rst_data", if0.tx_data, 8'h00);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_valid_w12", if1.tx_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic dump
        if0.tx_ready = 1'b1;
        push_frame(16'h1234, 16'hABCD);
        start_dump0();
        @(negedge clk);
        check("basic_first_busy", busy0, 1);
        check("basic_first_valid", if0.tx_valid, 1);
        check("basic_first_data", if0.tx_data, 8'hA5);
        wait_done0(1, n);
        check("basic_done_cycle", n, 35);
        check("basic_done_busy", busy0, 1);
        @(negedge clk);
        check("basic_idle_busy", busy0, 0);
        check("basic_idle_done", done0, 0);
        check("basic_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // snapshot isolation and ignored starts
        push_frame(16'h1234, 16'hABCD);
        start_dump0();
        dr0[0] = 16'hFFFF;
        repeat (9) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("snap_done_e35", done0, 1);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        check("snap_busy_fall_e36", busy0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("snap_no_second_frame", if0.tx_valid, 0);
        end
        check("snap_q_empty", exp_q.size(), 0);
        dr0[0] = 16'h1234;

        // random backpressure
        push_frame(16'h1234, 16'hABCD);
        stall_cnt = 0;
        bp_mode = 1'b1;
        start_dump0();
        wait_done0(0, n);
        check("bp_done_cycle", n, 35 + stall_cnt);
        bp_mode = 1'b0;
        @(posedge clk);
        #2 if0.tx_ready = 1'b1;
        check("bp_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // reset in the middle of a frame
        push_frame(16'h1234, 16'hABCD);
        start_dump0();
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", if0.tx_valid, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_data", if0.tx_data, 8'h00);
        check("midrst_bytes_sent", exp_q.size(), 28);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_resume", if0.tx_valid, 0);
        push_frame(16'h1234, 16'hABCD);
        start_dump0();
        @(negedge clk);
        check("midrst_new_hdr", if0.tx_data, 8'hA5);
        @(negedge clk);
        check("midrst_new_len", if0.tx_data, 8'h10);
        wait_done0(2, n);
        check("midrst_done_cycle", n, 35);
        @(posedge clk);
        #1;

        // WIDTH=12, DEPTH=3
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("w12_valid", if1.tx_valid, 1);
            check("w12_byte", if1.tx_data, exp1[k]);
        end
        @(negedge clk);
        check("w12_done", done1, 1);
        @(posedge clk);
        #1;

        // WIDTH=8, DEPTH=2
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w8_valid", if2.tx_valid, 1);
            check("w8_byte", if2.tx_data, exp2[k]);
        end
        @(negedge clk);
        check("w8_done_e5", done2, 1);
        @(negedge clk);
        check("w8_idle", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
